// File: rtl/sparse_result_collector_pkg.sv
// Shared definitions for the sparse result collector: FSM encoding, default sizes, window helpers.
// No logic; no latency or backpressure.
package sparse_result_collector_pkg;

    localparam int ACC_W_DEF  = 32;
    localparam int N_COLS_DEF = 4;
    localparam int K_LEN_DEF  = 8;
    localparam int CNT_W_DEF  = 16;

    localparam int CAP_LEN     = K_LEN_DEF + N_COLS_DEF - 1;
    localparam int TOTAL_SLOTS = K_LEN_DEF * N_COLS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    function automatic int cap_len(input int k_len, input int n_cols);
        return k_len + n_cols - 1;
    endfunction

    function automatic int total_slots(input int k_len, input int n_cols);
        return k_len * n_cols;
    endfunction

endpackage

// File: rtl/sparse_result_collector_mac.sv
// sparse_mac_counter: windowed popcount of bottom-row valid_op flags, accumulated per tile.
// Counts are published one cycle after the final beat is accepted; no handshake of its own.
module sparse_mac_counter
    import sparse_result_collector_pkg::*;
#(
    parameter int N_COLS = N_COLS_DEF,
    parameter int K_LEN  = K_LEN_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int CYC_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic [CYC_W-1:0]  cyc,
    input  logic [N_COLS-1:0] valid_op,
    input  logic              load,
    output logic [CNT_W-1:0]  mac_count,
    output logic [CNT_W-1:0]  skip_count
);

    localparam int TOTAL = total_slots(K_LEN, N_COLS);

    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] inc;

    // Column j is still reducing while j <= cyc <= K_LEN-1+j.
    always_comb begin
        inc = '0;
        for (int j = 0; j < N_COLS; j++) begin
            if (valid_op[j] && (int'(cyc) >= j) && (int'(cyc) <= K_LEN - 1 + j))
                inc = inc + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            mac_count  <= '0;
            skip_count <= '0;
        end else begin
            if (clear)
                acc <= '0;
            else if (en)
                acc <= acc + inc;
            if (load) begin
                mac_count  <= acc;
                skip_count <= CNT_W'(TOTAL) - acc;
            end
        end
    end

endmodule

// File: rtl/sparse_result_collector.sv
// Drains the bottom PE row: skewed per-column capture, then one column per valid/ready beat.
// First beat K_LEN+N_COLS cycles after start; beats hold under !out_ready. SPARSE_STATS_EN adds MAC stats.
module sparse_result_collector
    import sparse_result_collector_pkg::*;
#(
    parameter int N_COLS = N_COLS_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int K_LEN  = K_LEN_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    localparam int IDX_W = (N_COLS > 1) ? $clog2(N_COLS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [N_COLS*ACC_W-1:0] col_acc,
    input  logic [N_COLS-1:0]       col_valid_op,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [IDX_W-1:0]        out_col,
    output logic                    out_last,
    output logic                    busy,
    output logic                    tile_done,
    output logic [CNT_W-1:0]        mac_count,
    output logic [CNT_W-1:0]        skip_count
);

    localparam int CAPL  = cap_len(K_LEN, N_COLS);
    localparam int CYC_W = $clog2(CAPL + 1);

    state_t           state, state_nx;
    logic [CYC_W-1:0] cyc;
    logic [IDX_W-1:0] idx;
    logic [ACC_W-1:0] res_buf [N_COLS];
    logic             start_ok, cap_end, fire, last_beat;

    always_comb begin
        state_nx  = state;
        start_ok  = 1'b0;
        cap_end   = 1'b0;
        fire      = 1'b0;
        last_beat = (idx == IDX_W'(N_COLS - 1));
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_CAPTURE;
                    start_ok = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (cyc == CYC_W'(CAPL - 1)) begin
                    state_nx = ST_DRAIN;
                    cap_end  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    fire = 1'b1;
                    if (last_beat)
                        state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc       <= '0;
            idx       <= '0;
            tile_done <= 1'b0;
            for (int j = 0; j < N_COLS; j++)
                res_buf[j] <= '0;
        end else begin
            tile_done <= fire && last_beat;
            if (start_ok)
                cyc <= '0;
            else if (state == ST_CAPTURE)
                cyc <= cyc + CYC_W'(1);
            if (cap_end)
                idx <= '0;
            else if (fire)
                idx <= last_beat ? '0 : idx + IDX_W'(1);
            // Each column is sampled on its own skewed completion edge.
            if (state == ST_CAPTURE) begin
                for (int j = 0; j < N_COLS; j++) begin
                    if (cyc == CYC_W'(K_LEN - 1 + j))
                        res_buf[j] <= col_acc[j*ACC_W +: ACC_W];
                end
            end
        end
    end

    assign out_valid = (state == ST_DRAIN);
    assign out_data  = out_valid ? res_buf[idx] : '0;
    assign out_col   = out_valid ? idx : '0;
    assign out_last  = out_valid && last_beat;
    assign busy      = (state != ST_IDLE);

`ifdef SPARSE_STATS_EN
    sparse_mac_counter #(
        .N_COLS (N_COLS),
        .K_LEN  (K_LEN),
        .CNT_W  (CNT_W),
        .CYC_W  (CYC_W)
    ) u_mac_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .en         (state == ST_CAPTURE),
        .cyc        (cyc),
        .valid_op   (col_valid_op),
        .load       (fire && last_beat),
        .mac_count  (mac_count),
        .skip_count (skip_count)
    );
`else
    logic unused_valid_op;
    assign unused_valid_op = ^col_valid_op;
    assign mac_count       = '0;
    assign skip_count      = '0;
`endif

endmodule

// File: tb/tb_sparse_result_collector.sv
// Directed-plus-random bench for sparse_result_collector against a window-rule reference model.
module tb_sparse_result_collector;

    localparam int N_COLS = 4;
    localparam int ACC_W  = 32;
    localparam int K_LEN  = 8;
    localparam int CNT_W  = 16;
    localparam int CAPL   = K_LEN + N_COLS - 1;
    localparam int TOTAL  = K_LEN * N_COLS;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic [N_COLS*ACC_W-1:0] col_acc = '0;
    logic [N_COLS-1:0]       col_valid_op = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [ACC_W-1:0]        out_data;
    logic [1:0]              out_col;
    logic                    out_last;
    logic                    busy;
    logic                    tile_done;
    logic [CNT_W-1:0]        mac_count;
    logic [CNT_W-1:0]        skip_count;

    sparse_result_collector #(
        .N_COLS(N_COLS), .ACC_W(ACC_W), .K_LEN(K_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .col_acc(col_acc),
        .col_valid_op(col_valid_op), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_col(out_col), .out_last(out_last), .busy(busy),
        .tile_done(tile_done), .mac_count(mac_count), .skip_count(skip_count)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [ACC_W-1:0]  drv_acc [CAPL][N_COLS];
    logic [N_COLS-1:0] drv_vop [CAPL];
    logic [ACC_W-1:0]  exp_buf [N_COLS];
    int                exp_mac;
    int                prev_mac  = 0;
    int                prev_skip = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_garbage();
        for (int j = 0; j < N_COLS; j++)
            col_acc[j*ACC_W +: ACC_W] = $urandom;
        col_valid_op = N_COLS'($urandom);
    endtask

    // Reference: column j holds its final sum at cyc K_LEN-1+j and is active for cyc in [j, K_LEN-1+j].
    task automatic gen_tile(input int pat);
        for (int k = 0; k < CAPL; k++) begin
            for (int j = 0; j < N_COLS; j++) begin
                case (pat)
                    0:       drv_acc[k][j] = ACC_W'(100 + j);
                    1:       drv_acc[k][j] = ACC_W'(1000 * j + k);
                    default: drv_acc[k][j] = $urandom;
                endcase
            end
            case (pat)
                0:       drv_vop[k] = '1;
                2:       drv_vop[k] = '0;
                default: drv_vop[k] = N_COLS'($urandom);
            endcase
        end
        exp_mac = 0;
        for (int j = 0; j < N_COLS; j++) begin
            exp_buf[j] = drv_acc[K_LEN - 1 + j][j];
            for (int k = j; k <= K_LEN - 1 + j; k++)
                exp_mac += int'(drv_vop[k][j]);
        end
    endtask

    task automatic run_tile(input int pat, input int bp_beat, input int bp_len,
                            input bit glitch, input bit rst_mid);
        int k;
        int e_mac, e_skip;
        gen_tile(pat);
`ifdef SPARSE_STATS_EN
        e_mac  = exp_mac;
        e_skip = TOTAL - exp_mac;
`else
        e_mac  = 0;
        e_skip = 0;
`endif
        check("idle_busy", busy, 0);
        check("idle_mac_hold", mac_count, prev_mac);
        check("idle_skip_hold", skip_count, prev_skip);
        start = 1'b1;
        drive_garbage();
        tick();
        start = 1'b0;
        k = 0;
        while (!out_valid && k < 40) begin
            if (k < CAPL) begin
                for (int j = 0; j < N_COLS; j++)
                    col_acc[j*ACC_W +: ACC_W] = drv_acc[k][j];
                col_valid_op = drv_vop[k];
            end else begin
                drive_garbage();
            end
            out_ready = 1'($urandom);
            start = glitch && (k == 3);
            check("cap_busy", busy, 1);
            tick();
            start = 1'b0;
            k++;
        end
        check("latency", k + 1, K_LEN + N_COLS);
        for (int b = 0; b < N_COLS; b++) begin
            drive_garbage();
            if (b == bp_beat) begin
                for (int c = 0; c < bp_len; c++) begin
                    out_ready = 1'b0;
                    start = glitch;
                    check("bp_valid", out_valid, 1);
                    check("bp_data", out_data, exp_buf[b]);
                    check("bp_col", out_col, b);
                    check("bp_done", tile_done, 0);
                    tick();
                    start = 1'b0;
                end
            end
            out_ready = 1'b1;
            start = glitch && (b == N_COLS - 1);
            check("beat_valid", out_valid, 1);
            check("beat_data", out_data, exp_buf[b]);
            check("beat_col", out_col, b);
            check("beat_last", out_last, (b == N_COLS - 1));
            check("beat_done", tile_done, 0);
            tick();
            start = 1'b0;
            out_ready = 1'b0;
            if (rst_mid && b == 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_valid", out_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_mac", mac_count, 0);
                check("rst_skip", skip_count, 0);
                check("rst_done", tile_done, 0);
                tick();
                check("rst_done_after", tile_done, 0);
                check("rst_valid_after", out_valid, 0);
                prev_mac  = 0;
                prev_skip = 0;
                return;
            end
        end
        check("done_pulse", tile_done, 1);
        check("done_valid", out_valid, 0);
        check("done_busy", busy, 0);
        check("mac_count", mac_count, e_mac);
        check("skip_count", skip_count, e_skip);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("done_once", tile_done, 0);
        check("post_valid", out_valid, 0);
        prev_mac  = e_mac;
        prev_skip = e_skip;
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive_garbage();
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_col", out_col, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy0", busy, 0);
        check("rst_tile_done", tile_done, 0);
        check("rst_mac0", mac_count, 0);
        check("rst_skip0", skip_count, 0);
        rst = 1'b0;
        tick();
        check("idle_ready_ignored", out_valid, 0);
        out_ready = 1'b0;

        run_tile(0, -1, 0, 1'b0, 1'b0);   // dense tile
        run_tile(1, 1, 5, 1'b0, 1'b0);    // skewed capture with backpressure on beat 1
        run_tile(2, -1, 0, 1'b0, 1'b0);   // fully sparse
        run_tile(3, 1, 2, 1'b1, 1'b0);    // start glitches during capture/drain/final edge
        run_tile(3, -1, 0, 1'b0, 1'b1);   // reset mid-drain
        run_tile(0, -1, 0, 1'b0, 1'b0);   // normal tile after reset
        for (int t = 0; t < 6; t++)
            run_tile(3, int'($urandom_range(0, N_COLS - 1)), int'($urandom_range(0, 3)),
                     1'($urandom), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sparse_result_collector.md
Name: sparse_result_collector

Overview:
- Downstream drain stage for the bottom row of the sparse systolic PE array.
- After a `start` pulse, it samples each column's final accumulator at that column's skewed completion cycle into a result buffer.
- It then streams the buffered results out one column per beat over a valid/ready handshake.
- It also counts bottom-row MAC activity (executed vs skipped) per tile for sparsity statistics.

Parameters:
- N_COLS, 4: number of array columns drained.
- ACC_W, 32: accumulator width, signed; matches PE `acc_out`.
- K_LEN, 8: reduction length, i.e. accumulation cycles per tile.
- CNT_W, 16: width of the MAC statistics counters; must hold K_LEN*N_COLS.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  tile begin pulse; honoured only in IDLE.
- col_acc  in  N_COLS*ACC_W  bottom-row `acc_out` values; column j occupies bits [j*ACC_W +: ACC_W].
- col_valid_op  in  N_COLS  bottom-row `valid_op` flags, one per column.
- out_valid  out  1  result beat available.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  ACC_W  signed column result.
- out_col  out  clog2(N_COLS)  column index of the current beat.
- out_last  out  1  high on the beat for column N_COLS-1.
- busy  out  1  high in CAPTURE or DRAIN.
- tile_done  out  1  one-cycle pulse after the last beat is accepted.
- mac_count  out  CNT_W  executed MACs in the last tile.
- skip_count  out  CNT_W  skipped MACs in the last tile (K_LEN*N_COLS - mac_count).

Behaviour:
- Reset values: all outputs 0; state IDLE; cycle counter, buffer, index and counters cleared. Reset mid-operation aborts the tile immediately and emits no `tile_done`.
- FSM has three states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - `start`=1 → go to CAPTURE; `cyc`<=0; MAC accumulator <=0.
  - `mac_count` and `skip_count` keep the previous tile's values.
- CAPTURE:
  - `cyc` increments each cycle. On the edge where cyc == K_LEN-1+j, `buf[j]` <= column j of `col_acc`.
  - Column j's window is j ≤ cyc ≤ K_LEN-1+j. Each cycle, the accumulator adds the popcount of `col_valid_op[j]` over columns whose window includes the current `cyc`.
  - On the cyc == K_LEN+N_COLS-2 edge: final capture and count are applied, then go to DRAIN with `idx`<=0.
  - Latency from the `start` edge to the first `out_valid`=1 cycle is exactly K_LEN+N_COLS cycles.
- DRAIN:
  - Outputs: `out_valid`=1, `out_data`=`buf[idx]`, `out_col`=`idx`, `out_last`=(idx==N_COLS-1).
  - `out_data`, `out_col` and `out_last` are held stable while `out_valid` && !`out_ready`.
  - On `out_valid` && `out_ready`: `idx`++. If this is the last beat: go to IDLE, assert `tile_done` for one cycle, load `mac_count` and `skip_count` from the accumulator.
- `start` while `busy`=1 is ignored and does not restart the tile.
- `start` in the same cycle as the final `tile_done` transition is ignored; it is only accepted once the block is in IDLE.
- `out_valid` is never asserted outside DRAIN; `out_ready` is ignored outside DRAIN.
- Capture is a plain register copy. No arithmetic is applied to accumulator values; signed values pass through unchanged.

Optional Feature:
- Macro: SPARSE_STATS_EN.
- Defined: the MAC accumulator, `mac_count` and `skip_count` logic are present as specified.
- Undefined: the counting logic is omitted; `mac_count` and `skip_count` are tied to 0 and `col_valid_op` is unused. All other behaviour, including timing, is identical.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, CAPTURE, DRAIN).
  - Localparams CAP_LEN = K_LEN+N_COLS-1 and TOTAL_SLOTS = K_LEN*N_COLS.
  - ACC_W default shared with the PE.
- One natural sub-module: sparse_mac_counter, holding the windowed popcount and accumulator. It is instantiated only under SPARSE_STATS_EN.

Test Plan (N_COLS=4, K_LEN=8):
- Dense tile: all `col_valid_op`=1 for the whole window, `col_acc[j]`=100+j held throughout → `out_valid` rises 12 cycles after `start`; beats 100,101,102,103 with `out_col` 0..3; `out_last` on the 4th beat; `mac_count`=32, `skip_count`=0.
- Skewed capture: drive column j = 1000*j + cyc each cycle → captured values 7, 1008, 2009, 3010.
- Fully sparse tile: `col_valid_op`=0 throughout → `mac_count`=0, `skip_count`=32. Without SPARSE_STATS_EN, both counters stay 0 in every test.
- Backpressure: hold `out_ready`=0 for 5 cycles on beat 1 → `out_data` and `out_col`=1 stable throughout; `tile_done` pulses exactly once, on the cycle after beat 3 is accepted.
- `start` pulsed during CAPTURE and again during DRAIN → ignored; exactly 4 beats and one `tile_done` are produced.
- `rst` asserted in DRAIN after beat 1 → next cycle `out_valid`=0, `busy`=0, `mac_count`=0, no `tile_done`; a new `start` then completes a normal tile.
